// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory program loader.
// Also holds the state-to-output decode used for the loader's registered outputs.
package imem_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  typedef struct packed {
    logic byte_ready;
    logic cpu_rst;
    logic done;
    logic err;
  } ctl_t;

  // Output levels are pure functions of the state being entered.
  function automatic ctl_t ctl_of(state_t s);
    ctl_t c;
    c.byte_ready = (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHK);
    c.cpu_rst    = (s != DONE);
    c.done       = (s == DONE);
    c.err        = (s == ERR);
    return c;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-serial valid/ready stream feeding the program loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);

endinterface

// File: rtl/imem_byte_packer.sv
// Big-endian 4-byte packer: first byte shifted in lands in word[31:24].
// word_valid pulses for one cycle after the edge that shifts in the 4th byte.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_last,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0] cnt;

  // High when the next shifted byte completes a word.
  assign word_last = (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt        <= 2'd0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= shift_en && word_last;
      if (shift_en) begin
        word <= {word[WORD_W-BYTE_W-1:0], byte_in};
        cnt  <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed program loader: length, big-endian words and XOR checksum in, instruction
// memory writes out; holds the core in reset until a verified image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_loader_if.slave      bs,
  output logic              imem_wr_en,
  output logic [31:0]       imem_wr_addr,
  output logic [WORD_W-1:0] imem_wr_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);

  state_t            state;
  ctl_t              ctl;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  word_idx;
  logic [BYTE_W-1:0] xor_q;
  logic [LEN_W-1:0]  len_new;
  logic              xfer;
  logic              launch;
  logic              shift_en;
  logic              word_last;

  assign xfer     = bs.byte_valid && ctl.byte_ready;
  assign launch   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign shift_en = xfer && (state == DATA);
  assign len_new  = {len_q[15:8], bs.byte_data};

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (launch),
    .shift_en   (shift_en),
    .byte_in    (bs.byte_data),
    .word_last  (word_last),
    .word_valid (imem_wr_en),
    .word       (imem_wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ctl          <= ctl_of(IDLE);
      len_q        <= '0;
      word_idx     <= '0;
      xor_q        <= '0;
      imem_wr_addr <= BASE_ADDR;
    end else if (launch) begin
      state    <= LEN_HI;
      ctl      <= ctl_of(LEN_HI);
      word_idx <= '0;
      xor_q    <= '0;
    end else if (xfer) begin
      // The check byte itself is not folded into the running XOR.
      if (state != CHK) xor_q <= xor_q ^ bs.byte_data;
      case (state)
        LEN_HI: begin
          len_q[15:8] <= bs.byte_data;
          state       <= LEN_LO;
          ctl         <= ctl_of(LEN_LO);
        end
        LEN_LO: begin
          len_q[7:0] <= bs.byte_data;
          if ({16'd0, len_new} > MAX_W32) begin
            state <= ERR;
            ctl   <= ctl_of(ERR);
          end else if (len_new == '0) begin
            state <= CHK;
            ctl   <= ctl_of(CHK);
          end else begin
            state <= DATA;
            ctl   <= ctl_of(DATA);
          end
        end
        DATA: begin
          if (word_last) begin
            imem_wr_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
            word_idx     <= word_idx + 16'd1;
            if ((word_idx + 16'd1) == len_q) begin
              state <= CHK;
              ctl   <= ctl_of(CHK);
            end
          end
        end
        CHK: begin
          if (bs.byte_data == xor_q) begin
            state <= DONE;
            ctl   <= ctl_of(DONE);
          end else begin
            state <= ERR;
            ctl   <= ctl_of(ERR);
          end
        end
        default: ;
      endcase
    end
  end

  assign bs.byte_ready = ctl.byte_ready;
  assign cpu_rst       = ctl.cpu_rst;
  assign done          = ctl.done;
  assign err           = ctl.err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized images and
// byte_valid gaps, checked against a frame-level reference model.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 256;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_wr_en;
  logic [31:0] imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        cpu_rst;
  logic        done;
  logic        err;

  imem_loader_if bus();

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bs           (bus),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   acc_cnt = 0;
  wr_t  wq[$];
  wr_t  exp_q[$];
  logic exp_done;
  logic obs_done, obs_err, obs_cpu_rst, obs_ready;

  always @(posedge clk) begin
    if (!rst && bus.byte_valid && bus.byte_ready) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge clk) begin
    if (imem_wr_en) wq.push_back({imem_wr_addr, imem_wr_data});
  end

  function automatic bq_t nominal();
    bq_t s;
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h8B};
    return s;
  endfunction

  // Frame-level model: decode the stream by its framing rules.
  task automatic ref_model(input bq_t s);
    int unsigned len;
    logic [7:0]  x;
    exp_q.delete();
    exp_done = 1'b0;
    len = {s[0], s[1]};
    x   = s[0] ^ s[1];
    if (len > MAXW) return;
    for (int w = 0; w < int'(len); w++) begin
      logic [31:0] wd;
      wd = {s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]};
      exp_q.push_back({BASE + 32'(4*w), wd});
      x = x ^ wd[31:24] ^ wd[23:16] ^ wd[15:8] ^ wd[7:0];
    end
    exp_done = (s[2+4*len] == x);
  endtask

  function automatic bq_t gen_image(int len, bit corrupt);
    bq_t        s;
    logic [7:0] x;
    s.push_back(8'(len >> 8));
    s.push_back(8'(len));
    if (len > MAXW) return s;
    for (int i = 0; i < 4*len; i++) s.push_back(8'($urandom));
    x = 8'h00;
    foreach (s[i]) x = x ^ s[i];
    s.push_back(corrupt ? ~x : x);
    return s;
  endfunction

  // Entered and left just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte_ready=%b required=1", bus.byte_ready);
      bus.byte_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic do_load(input bq_t s, input int gap_pct, input int start_at);
    wq.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (s[i]) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        bus.byte_valid = 1'b0;
        repeat ($urandom_range(3, 1)) @(negedge clk);
      end
      send_byte(s[i]);
      if (i == start_at) begin
        bus.byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    bus.byte_valid = 1'b0;
    obs_done    = done;
    obs_err     = err;
    obs_cpu_rst = cpu_rst;
    obs_ready   = bus.byte_ready;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    total++; if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.byte_ready); end
    total++; if (imem_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", imem_wr_en); end
    total++; if (imem_wr_addr !== BASE) begin bad++; $display("FAIL rst_addr: got %h want %h", imem_wr_addr, BASE); end
    total++; if (imem_wr_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", imem_wr_data); end
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
  endtask

  task automatic test_nominal();
    wr_t w0, w1;
    do_load(nominal(), 0, -1);
    w0 = (wq.size() > 0) ? wq[0] : '0;
    w1 = (wq.size() > 1) ? wq[1] : '0;
    total++; if (wq.size() != 2) begin bad++; $display("FAIL nom_wr_count: got %0d want 2", wq.size()); end
    total++; if (w0 !== {32'h0, 32'h2008_0005}) begin bad++; $display("FAIL nom_wr0: got %h want 0000000020080005", w0); end
    total++; if (w1 !== {32'h4, 32'hAC08_0000}) begin bad++; $display("FAIL nom_wr1: got %h want 00000004ac080000", w1); end
    total++; if (obs_done !== 1'b1) begin bad++; $display("FAIL nom_done: got %b want 1", obs_done); end
    total++; if (obs_err !== 1'b0) begin bad++; $display("FAIL nom_err: got %b want 0", obs_err); end
    total++; if (obs_cpu_rst !== 1'b0) begin bad++; $display("FAIL nom_cpu_rst: got %b want 0", obs_cpu_rst); end
  endtask

  task automatic test_load(input string name, input bq_t s, input int gap_pct, input int start_at);
    int a0;
    ref_model(s);
    a0 = acc_cnt;
    do_load(s, gap_pct, start_at);
    total++;
    if (wq.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s wr_count: got %0d want %0d", name, wq.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        total++;
        if (wq[k] !== exp_q[k]) begin
          bad++;
          $display("FAIL %s wr[%0d]: got %h want %h", name, k, wq[k], exp_q[k]);
        end
      end
    end
    total++; if (obs_done !== exp_done) begin bad++; $display("FAIL %s done: got %b want %b", name, obs_done, exp_done); end
    total++; if (obs_err !== !exp_done) begin bad++; $display("FAIL %s err: got %b want %b", name, obs_err, !exp_done); end
    total++; if (obs_cpu_rst !== !exp_done) begin bad++; $display("FAIL %s cpu_rst: got %b want %b", name, obs_cpu_rst, !exp_done); end
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL %s ready_after: got %b want 0", name, obs_ready); end
    total++; if (acc_cnt - a0 != s.size()) begin bad++; $display("FAIL %s accepted: got %0d want %0d", name, acc_cnt - a0, s.size()); end
  endtask

  task automatic test_restart_from_done();
    bq_t s;
    s = nominal();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL redo_cpu_rst: got %b want 1", cpu_rst); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL redo_done: got %b want 0", done); end
    total++; if (bus.byte_ready !== 1'b1) begin bad++; $display("FAIL redo_ready: got %b want 1", bus.byte_ready); end
    foreach (s[i]) send_byte(s[i]);
    bus.byte_valid = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL redo_final_done: got %b want 1", done); end
  endtask

  task automatic test_oversize();
    int a0;
    bq_t s;
    s = '{8'h01, 8'h01};
    test_load("oversize", s, 0, -1);
    a0 = acc_cnt;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    repeat (5) @(negedge clk);
    bus.byte_valid = 1'b0;
    total++; if (acc_cnt != a0) begin bad++; $display("FAIL oversize_hold_accept: got %0d want 0", acc_cnt - a0); end
    total++; if (wq.size() != 0) begin bad++; $display("FAIL oversize_hold_writes: got %0d want 0", wq.size()); end
  endtask

  task automatic test_reset_mid_load();
    bq_t  s;
    wr_t  w0;
    s = nominal();
    wq.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(s[i]);
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    w0 = (wq.size() > 0) ? wq[0] : '0;
    total++; if (wq.size() != 1) begin bad++; $display("FAIL midrst_pre_writes: got %0d want 1", wq.size()); end
    total++; if (w0 !== {32'h0, 32'h2008_0005}) begin bad++; $display("FAIL midrst_wr0: got %h want 0000000020080005", w0); end
    total++; if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b want 0", bus.byte_ready); end
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL midrst_cpu_rst: got %b want 1", cpu_rst); end
    total++; if (imem_wr_addr !== BASE) begin bad++; $display("FAIL midrst_addr: got %h want %h", imem_wr_addr, BASE); end
    total++; if (imem_wr_data !== 32'h0) begin bad++; $display("FAIL midrst_data: got %h want 0", imem_wr_data); end
    wq.delete();
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAC;
    repeat (10) @(negedge clk);
    bus.byte_valid = 1'b0;
    total++; if (wq.size() != 0) begin bad++; $display("FAIL midrst_post_writes: got %0d want 0", wq.size()); end
    // Restart with a stray start during DATA, which must be ignored.
    test_load("restart_ignored_start", s, 0, 6);
  endtask

  task automatic test_random();
    bq_t s;
    int  len;
    int  sa;
    for (int it = 0; it < 20; it++) begin
      len = int'($urandom_range(8, 0));
      s   = gen_image(len, $urandom_range(3, 0) == 0);
      sa  = (len > 0 && it % 3 == 0) ? int'($urandom_range(4*len, 2)) : -1;
      test_load("random", s, 30, sa);
    end
    s = gen_image(int'($urandom_range(65535, MAXW + 1)), 1'b0);
    test_load("random_oversize", s, 30, -1);
    s = gen_image(MAXW, 1'b0);
    test_load("max_len", s, 0, -1);
  endtask

  initial begin
    bq_t s;
    test_reset();
    test_nominal();
    test_restart_from_done();
    s = nominal();
    s[10] = 8'h8A;
    test_load("bad_checksum", s, 0, -1);
    test_oversize();
    s = '{8'h00, 8'h00, 8'h00};
    test_load("zero_len", s, 0, -1);
    test_load("stall", nominal(), 60, -1);
    test_load("back_to_back", nominal(), 0, -1);
    test_reset_mid_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
